keccak_padder: RTL and testbench
================================

Name: keccak_padder

Overview:
- Upstream neighbour of the Keccak-f permutation core.
- Accepts the message as a stream of 64-bit words and packs them into rate-sized blocks.
- Applies multi-rate padding (PAD_BYTE … 0x80) to the final block.
- Presents each 1344-bit block to the permutation's in/in_ready/ack/last_in handshake; the rate is selected per message by mode.

Parameters:
- PAD_BYTE, 8'h06, domain/first padding byte (8'h01 for original Keccak).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  2  rate select: 0 = 576 bits (9 words), 1 = 1088 (17), 2 = 1344 (21), 3 = 1088 (17).
- in  input  64  message word; byte 0 = in[63:56].
- in_ready  input  1  in/is_last/byte_num valid this cycle.
- is_last  input  1  current word is the last of the message.
- byte_num  input  3  valid bytes in a last word (0–7); ignored when is_last=0.
- buffer_full  output  1  block buffer occupied; words presented now are not taken.
- out  output  1344  block to the permutation; rate bits in out[RATE-1:0], first word at out[RATE-1:RATE-64].
- out_ready  output  1  block complete; drives the permutation's in_ready.
- last_out  output  1  current block is the final one; drives last_in.
- f_ack  input  1  permutation accept pulse (its ack).

Behaviour:
- Reset (async, any time, including mid-block):
  - out = 0, out_ready = 0, last_out = 0, buffer_full = 0.
  - Word counter = 0, state = FILL, mode register = 0.
- States: FILL (taking input words), PAD (generating zero words after the last word), FULL (waiting for f_ack).
- Word accept:
  - A word is taken when in_ready=1 and state=FILL; buffer_full = (state != FILL).
  - Words are shifted in: out <= {out[1279:0], word}.
  - Bits above RATE-1 are forced to 0 when the block completes.
- Mode:
  - mode is registered on the first accepted word of each message (counter=0 and first block).
  - The registered value is used for every block of that message; changes mid-message are ignored.
- Last word (is_last=1):
  - Bytes 0..byte_num-1 are taken from in.
  - Byte byte_num = PAD_BYTE; remaining bytes = 0.
  - byte_num=0 means the word carries padding only; a full 8-byte last word is sent as a normal word followed by is_last with byte_num=0.
  - If counter < RATE_WORDS-1, go to PAD; otherwise go to FULL.
- PAD:
  - Shifts in one 64'h0 word per cycle until the block holds RATE_WORDS words; no input is accepted.
- Final 0x80:
  - The final word of the final block has byte 7 (bits [7:0]) ORed with 8'h80.
  - When byte_num=7 lands in word RATE_WORDS-1, that byte becomes PAD_BYTE|8'h80 (8'h86 by default).
  - A final word written by PAD gets 64'h80.
- Block complete:
  - On the edge that stores word RATE_WORDS-1, the counter returns to 0 and state becomes FULL.
  - out_ready=1 and last_out=(final block) from the next cycle.
- FULL:
  - out, out_ready and last_out are held stable until f_ack=1.
  - On that edge out_ready and last_out drop to 0 and state becomes FILL.
  - After the final block, the next accepted word starts a new message.
- Simultaneous events:
  - f_ack and in_ready in the same cycle: the word is not taken; buffer_full is still 1 that cycle.
  - f_ack while out_ready=0 is ignored.
  - in_ready during PAD/FULL is ignored; the source must hold the word.
- Latency: last word accepted at cycle t with counter=k → out_ready at t+RATE_WORDS-k.
- Throughput: one word per cycle in FILL.

Test Plan:
- Empty message, mode=2: single word is_last=1, byte_num=0.
  - 21 cycles later out_ready=1, last_out=1.
  - out[1343:1280]=64'h0600000000000000, out[63:0]=64'h0000000000000080, all other bits 0.
- "abc", mode=0: in=64'h6162630000000000, is_last=1, byte_num=3.
  - out[575:512]=64'h6162630600000000, out[63:0]=64'h80, out[1343:576]=0.
  - Hold f_ack=0 for 10 cycles → out stable, buffer_full=1, in_ready pulses ignored.
- Mode=0: 8 words of 64'h1111111111111111, then last word 64'h22222222222222FF with byte_num=7.
  - out[63:0]=64'h2222222222222286, out_ready the cycle after, no PAD cycles.
- Mode=0: 9 full words, then is_last byte_num=0.
  - First block: last_out=0; ack it.
  - Second block: out[575:512]=64'h0600000000000000, out[63:0]=64'h80, last_out=1.
  - Mode changed to 2 between the blocks is ignored (second block still 9 words).
- f_ack asserted in the same cycle as a new word after a block → word taken one cycle later, no word lost or duplicated; stream of 18 distinct words in mode=1 yields two correct blocks.
- reset asserted asynchronously mid-FILL (counter=5) and in FULL → all outputs 0 immediately; next message of 1 word produces a correct single block.

Source files
------------

// File: rtl/keccak_padder.sv
// Keccak message padder: packs 64-bit message words into rate-sized blocks,
// appends multi-rate padding (PAD_BYTE ... 0x80) and hands each completed
// block to the permutation core through an out_ready / f_ack handshake.
module keccak_padder #(
    parameter logic [7:0] PAD_BYTE = 8'h06
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic [63:0]   in,
    input  logic          in_ready,
    input  logic          is_last,
    input  logic [2:0]    byte_num,
    output logic          buffer_full,
    output logic [1343:0] out,
    output logic          out_ready,
    output logic          last_out,
    input  logic          f_ack
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [4:0]      count_reg;
    logic [1:0]      mode_reg;
    logic            in_msg_reg;
    logic            last_reg;
    logic [1343:0]   out_reg;

    logic            first_word;
    logic [1:0]      mode_eff;
    logic [4:0]      rate_words;
    logic [1343:0]   rate_mask;
    logic            block_end;
    logic [63:0]     last_word;
    logic [63:0]     word;
    logic            shift_en;
    logic            done;

    // The very first word of a message uses the live mode input, since the
    // mode register is only loaded on that same edge.
    assign first_word = (count_reg == 5'd0) && !in_msg_reg;
    assign mode_eff   = first_word ? mode : mode_reg;

    // Block length and the mask that clears bits above the rate.
    always_comb begin
        case (mode_eff)
            2'd0: begin
                rate_words = 5'd9;
                rate_mask  = {{768{1'b0}}, {576{1'b1}}};
            end
            2'd2: begin
                rate_words = 5'd21;
                rate_mask  = {1344{1'b1}};
            end
            default: begin
                rate_words = 5'd17;
                rate_mask  = {{256{1'b0}}, {1088{1'b1}}};
            end
        endcase
    end

    assign block_end = (count_reg == rate_words - 5'd1);

    // Last word: keep bytes below byte_num, put PAD_BYTE at byte_num, zero the rest.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_last_byte
            assign last_word[63-8*gi -: 8] =
                (3'(gi) < byte_num)  ? in[63-8*gi -: 8] :
                (3'(gi) == byte_num) ? PAD_BYTE : 8'h00;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and selection of the word shifted in this cycle.
    always_comb begin
        state_next = state_reg;
        shift_en   = 1'b0;
        done       = 1'b0;
        word       = 64'h0;
        case (state_reg)
            FILL: begin
                if (in_ready) begin
                    shift_en = 1'b1;
                    word     = is_last ? last_word : in;
                    if (is_last && block_end) begin
                        word[7:0] = word[7:0] | 8'h80;
                    end
                    if (block_end) begin
                        state_next = FULL;
                        done       = 1'b1;
                    end else if (is_last) begin
                        state_next = PAD;
                    end
                end
            end
            PAD: begin
                shift_en = 1'b1;
                if (block_end) begin
                    word       = 64'h80;
                    state_next = FULL;
                    done       = 1'b1;
                end
            end
            FULL: begin
                if (f_ack) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Block buffer, word counter, message mode and final-block tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg    <= '0;
            count_reg  <= 5'd0;
            mode_reg   <= 2'd0;
            in_msg_reg <= 1'b0;
            last_reg   <= 1'b0;
        end else begin
            if (shift_en) begin
                if (done) begin
                    out_reg   <= {out_reg[1279:0], word} & rate_mask;
                    count_reg <= 5'd0;
                    last_reg  <= (state_reg == PAD) || is_last;
                end else begin
                    out_reg   <= {out_reg[1279:0], word};
                    count_reg <= count_reg + 5'd1;
                end
            end
            if (state_reg == FILL && in_ready) begin
                in_msg_reg <= 1'b1;
                if (first_word) begin
                    mode_reg <= mode;
                end
            end
            if (state_reg == FULL && f_ack) begin
                last_reg <= 1'b0;
                if (last_reg) begin
                    in_msg_reg <= 1'b0;
                end
            end
        end
    end

    assign buffer_full = (state_reg != FILL);
    assign out_ready   = (state_reg == FULL);
    assign last_out    = last_reg;
    assign out         = out_reg;

endmodule

// File: tb/tb_keccak_padder.sv
// Bench for keccak_padder: random messages are padded by a byte-level model
// and the produced blocks are compared against the DUT block by block.
module tb_keccak_padder;

    localparam logic [7:0] PAD = 8'h06;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic [63:0]   in;
    logic          in_ready;
    logic          is_last;
    logic [2:0]    byte_num;
    logic          buffer_full;
    logic [1343:0] out;
    logic          out_ready;
    logic          last_out;
    logic          f_ack;

    keccak_padder #(.PAD_BYTE(PAD)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out         (out),
        .out_ready   (out_ready),
        .last_out    (last_out),
        .f_ack       (f_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int last_acc_cyc = 0;
    int blk_no = 0;

    // Stimulus words and expected blocks
    logic [63:0]   st_word[$];
    bit            st_last[$];
    logic [2:0]    st_bn[$];
    bit            st_first[$];
    logic [1:0]    st_mode[$];
    logic [1343:0] eb[$];
    bit            el[$];
    int            elat[$];
    int            ehold[$];

    task automatic chk(input string tag, input logic [1343:0] got, input logic [1343:0] exp);
        n_cmp++;
        if (got !== exp) begin
            int c;
            c = 0;
            for (int i = 20; i >= 0; i--)
                if (got[i*64 +: 64] !== exp[i*64 +: 64]) c = i;
            n_err++;
            $display("FAIL %s: word %0d got %h expected %h", tag, c, got[c*64 +: 64], exp[c*64 +: 64]);
        end
    endtask

    // Byte-level reference: message bytes, PAD byte, zero fill to a rate
    // multiple, 0x80 ORed into the last byte, then split into blocks.
    task automatic add_msg(input int m, input int nw, input int bn, input int hold,
                           input bit fix, input logic [63:0] fw, input logic [63:0] lw);
        int rw, rb, len, plen, nblk;
        logic [7:0] pb[$];
        logic [63:0] w;
        logic [1343:0] blk;
        rw = (m == 0) ? 9 : (m == 2) ? 21 : 17;
        rb = rw * 8;
        for (int i = 0; i < nw; i++) begin
            w = fix ? fw : {$urandom, $urandom};
            st_word.push_back(w); st_last.push_back(1'b0); st_bn.push_back(3'($urandom_range(0, 7)));
            st_first.push_back(i == 0); st_mode.push_back(2'(m));
            for (int j = 0; j < 8; j++) pb.push_back(w[63-8*j -: 8]);
        end
        w = fix ? lw : {$urandom, $urandom};
        st_word.push_back(w); st_last.push_back(1'b1); st_bn.push_back(3'(bn));
        st_first.push_back(nw == 0); st_mode.push_back(2'(m));
        for (int j = 0; j < bn; j++) pb.push_back(w[63-8*j -: 8]);
        len  = pb.size();
        plen = (len / rb + 1) * rb;
        pb.push_back(PAD);
        while (pb.size() < plen) pb.push_back(8'h00);
        pb[plen-1] = pb[plen-1] | 8'h80;
        nblk = plen / rb;
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int i = 0; i < rb; i++) blk[rw*64-1-8*i -: 8] = pb[b*rb+i];
            eb.push_back(blk);
            el.push_back(b == nblk - 1);
            elat.push_back((b == nblk - 1) ? (rw - 1 - (nw % rw)) : -1);
            ehold.push_back((hold < 0) ? int'($urandom_range(0, 3)) : hold);
        end
    endtask

    task automatic drive_all();
        @(negedge clk);
        while (st_word.size() > 0) begin
            int g;
            if ($urandom_range(0, 3) == 0) begin
                in_ready = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            in       = st_word[0];
            is_last  = st_last[0];
            byte_num = st_bn[0];
            mode     = st_first[0] ? st_mode[0] : 2'($urandom_range(0, 3));
            in_ready = 1'b1;
            g = 0;
            while (buffer_full && g < 500) begin
                @(negedge clk);
                g++;
            end
            if (g >= 500) begin
                chk("drv_stall", 1344'(buffer_full), 1344'(1'b0));
                break;
            end
            if (st_last[0]) last_acc_cyc = cyc + 1;
            void'(st_word.pop_front()); void'(st_last.pop_front()); void'(st_bn.pop_front());
            void'(st_first.pop_front()); void'(st_mode.pop_front());
            @(negedge clk);
        end
        in_ready = 1'b0;
        is_last  = 1'b0;
        st_word.delete(); st_last.delete(); st_bn.delete(); st_first.delete(); st_mode.delete();
    endtask

    task automatic consume_all();
        int nb;
        nb = eb.size();
        @(negedge clk);
        for (int b = 0; b < nb; b++) begin
            int g, lat, hold;
            logic [1343:0] eblk;
            bit elast;
            g = 0;
            while (!out_ready && g < 300) begin
                @(negedge clk);
                g++;
            end
            chk("out_ready", 1344'(out_ready), 1344'(1'b1));
            if (!out_ready) break;
            eblk = eb.pop_front(); elast = el.pop_front();
            lat = elat.pop_front(); hold = ehold.pop_front();
            chk("block", out, eblk);
            chk("last_out", 1344'(last_out), 1344'(elast));
            if (lat >= 0) chk("latency", 1344'(cyc - last_acc_cyc), 1344'(lat));
            $display("block %0d received last_out=%0d hold=%0d", blk_no, last_out, hold);
            blk_no++;
            repeat (hold) begin
                @(negedge clk);
                chk("hold_out", out, eblk);
                chk("hold_full", 1344'(buffer_full), 1344'(1'b1));
            end
            f_ack = 1'b1;
            @(negedge clk);
            f_ack = 1'b0;
            chk("ack_drop", 1344'(out_ready), 1344'(1'b0));
            chk("ack_last", 1344'(last_out), 1344'(1'b0));
        end
        eb.delete(); el.delete(); elat.delete(); ehold.delete();
    endtask

    task automatic run();
        fork
            drive_all();
            consume_all();
        join
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, out, '0);
        chk({tag, "_rdy"}, 1344'(out_ready), 1344'(1'b0));
        chk({tag, "_last"}, 1344'(last_out), 1344'(1'b0));
        chk({tag, "_full"}, 1344'(buffer_full), 1344'(1'b0));
    endtask

    initial begin
        reset = 1'b1; mode = 2'd0; in = '0; in_ready = 1'b0;
        is_last = 1'b0; byte_num = 3'd0; f_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // Stray f_ack with no block pending
        f_ack = 1'b1;
        @(negedge clk);
        f_ack = 1'b0;
        chk("stray_ack_rdy", 1344'(out_ready), 1344'(1'b0));
        chk("stray_ack_full", 1344'(buffer_full), 1344'(1'b0));

        add_msg(2, 0, 0, -1, 1'b1, 64'h0, 64'h0);
        add_msg(0, 0, 3, 10, 1'b1, 64'h0, 64'h6162630000000000);
        add_msg(0, 8, 7, -1, 1'b1, 64'h1111111111111111, 64'h22222222222222FF);
        add_msg(0, 9, 0, -1, 1'b0, 64'h0, 64'h0);
        add_msg(1, 17, 0, 0, 1'b0, 64'h0, 64'h0);
        for (int i = 0; i < 12; i++)
            add_msg(int'($urandom_range(0, 3)), int'($urandom_range(0, 25)),
                    int'($urandom_range(0, 7)), -1, 1'b0, 64'h0, 64'h0);
        run();

        // Asynchronous reset in the middle of filling a block
        @(negedge clk);
        mode = 2'd0; is_last = 1'b0; in_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in = {$urandom, $urandom} | 64'h1;
            @(negedge clk);
        end
        in_ready = 1'b0;
        #2 reset = 1'b1;
        #1 chk_zero("rst_fill");
        @(negedge clk);
        reset = 1'b0;
        add_msg(int'($urandom_range(0, 3)), 0, int'($urandom_range(0, 7)), -1, 1'b0, 64'h0, 64'h0);
        run();

        // Asynchronous reset while a block waits for f_ack
        @(negedge clk);
        mode = 2'd2; in = 64'h6162630000000000; is_last = 1'b1; byte_num = 3'd3; in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0; is_last = 1'b0;
        begin
            int g;
            g = 0;
            while (!out_ready && g < 60) begin
                @(negedge clk);
                g++;
            end
        end
        chk("full_before_rst", 1344'(out_ready), 1344'(1'b1));
        #2 reset = 1'b1;
        #1 chk_zero("rst_full");
        @(negedge clk);
        reset = 1'b0;
        add_msg(0, 0, int'($urandom_range(0, 7)), -1, 1'b0, 64'h0, 64'h0);
        run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
